// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg -- shared widths and helpers for the streaming 2-D convolution.
//   ACC_W        : accumulator width; holds 25 full-scale products plus bias.
//   PIX_W        : pixel / weight / bias width.
//   PROD_W       : width of one registered pixel*weight product.
//   bias_addr()  : write address that selects the bias (weights use 0..K*K-1).
//   last_pos()   : last row/column index at which a window is emitted.
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int ACC_W  = 21;
    localparam int PIX_W  = 8;
    localparam int PROD_W = 16;

    function automatic int bias_addr(input int k);
        return k * k;
    endfunction

    // Bottom-right index of the last stride-aligned window along an axis of n.
    function automatic int last_pos(input int k, input int n, input int stride);
        return (k - 1) + ((n - k) / stride) * stride;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// ---------------------------------------------------------------------------
// conv_line_buf -- one image line of pixel delay.
//   iCLK : clock
//   iEn  : shift enable (one accepted pixel)
//   iD   : pixel in
//   oQ   : pixel accepted DEPTH enables ago (same column, previous line)
// Storage has no reset; stale contents are never used by the window logic.
// ---------------------------------------------------------------------------
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = PIX_W
) (
    input  logic             iCLK,
    input  logic             iEn,
    input  logic [WIDTH-1:0] iD,
    output logic [WIDTH-1:0] oQ
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    always_ff @(posedge iCLK) begin
        if (iEn) mem <= {mem[DEPTH-2:0], iD};
    end

    assign oQ = mem[DEPTH-1];

endmodule

// File: rtl/conv2d_stream.sv
// ---------------------------------------------------------------------------
// conv2d_stream -- raster-order KxK convolution with stride, saturation, ReLU.
//   iCLK, iRST        : clock, synchronous active-high reset
//   iWren/iADDR/iWeight : shadow weight (0..K*K-1) and bias (K*K) writes
//   iRelu             : ReLU enable, latched with the start of frame
//   iSof/iValid/iX    : pixel stream; iSof marks pixel (0,0)
//   oPsum/oValid      : result, valid 3 cycles after the qualifying pixel
//   oDone             : pulse with the last result of the frame
// ---------------------------------------------------------------------------
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int K      = 5,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int STRIDE = 1,
    parameter int BW_OUT = 16
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iWren,
    input  logic [4:0]               iADDR,
    input  logic signed [PIX_W-1:0]  iWeight,
    input  logic                     iRelu,
    input  logic                     iSof,
    input  logic                     iValid,
    input  logic signed [PIX_W-1:0]  iX,
    output logic signed [BW_OUT-1:0] oPsum,
    output logic                     oValid,
    output logic                     oDone
);

    localparam int         NW     = K * K;
    localparam int         CW     = $clog2(IMG_W);
    localparam int         RW     = $clog2(IMG_H);
    localparam logic [4:0] BADDR  = 5'(bias_addr(K));
    localparam int         LAST_R = last_pos(K, IMG_H, STRIDE);
    localparam int         LAST_C = last_pos(K, IMG_W, STRIDE);

    localparam int     SAT_W = (BW_OUT < ACC_W) ? BW_OUT : ACC_W;
    localparam longint SMAX_L = (longint'(1) <<< (SAT_W - 1)) - 1;
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(SMAX_L);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-SMAX_L - 1);

    // ---- weights: shadow written any time, active loaded at frame start ----
    logic [NW-1:0][PIX_W-1:0] sh_w, act_w;
    logic [PIX_W-1:0]         sh_b, act_b;
    logic                     act_relu;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sh_w <= '0;
            sh_b <= '0;
        end else if (iWren) begin
            if (iADDR == BADDR) sh_b <= iWeight;
            for (int i = 0; i < NW; i++)
                if (iADDR == 5'(i)) sh_w[i] <= iWeight;
        end
    end

    // ---- pixel acceptance and position ----
    // armed drops after the last pixel of a frame (and at reset) so that
    // stray pixels are ignored until the next iSof.
    logic          armed, acc, sof_acc, last_px, qual, done_px;
    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;

    assign acc     = iValid && (iSof || armed);
    assign sof_acc = acc && iSof;
    assign cur_col = iSof ? '0 : col;
    assign cur_row = iSof ? '0 : row;
    assign last_px = (cur_col == CW'(IMG_W - 1)) && (cur_row == RW'(IMG_H - 1));

    always_comb begin
        qual = acc && (int'(cur_row) >= K - 1) && (int'(cur_col) >= K - 1);
        if (qual)
            qual = ((int'(cur_row) - (K - 1)) % STRIDE == 0) &&
                   ((int'(cur_col) - (K - 1)) % STRIDE == 0);
        done_px = qual && (cur_row == RW'(LAST_R)) && (cur_col == CW'(LAST_C));
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            armed    <= 1'b0;
            col      <= '0;
            row      <= '0;
            act_w    <= '0;
            act_b    <= '0;
            act_relu <= 1'b0;
        end else if (acc) begin
            armed <= !last_px;
            if (cur_col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= RW'(cur_row + 1'b1);
            end else begin
                col <= CW'(cur_col + 1'b1);
                row <= cur_row;
            end
            if (iSof) begin
                act_w    <= sh_w;
                act_b    <= sh_b;
                act_relu <= iRelu;
            end
        end
    end

    // ---- line buffers: colv[j] is the pixel j lines above the current one ----
    logic [K-2:0][PIX_W-1:0] lb_in, lb_out;
    logic [K-1:0][PIX_W-1:0] colv;

    assign colv[0] = iX;

    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        if (g == 0) begin : g_head
            assign lb_in[g] = iX;
        end else begin : g_chain
            assign lb_in[g] = lb_out[g-1];
        end
        assign colv[g+1] = lb_out[g];

        conv_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb (
            .iCLK (iCLK),
            .iEn  (acc),
            .iD   (lb_in[g]),
            .oQ   (lb_out[g])
        );
    end

    // ---- stage 1: window, row 0 = oldest line, column K-1 = newest pixel ----
    logic [K-1:0][K-1:0][PIX_W-1:0] win;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            win <= '0;
        end else if (acc) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) win[i][j] <= win[i][j+1];
                win[i][K-1] <= colv[K-1-i];
            end
        end
    end

    // ---- stage 2: products ----
    logic [NW-1:0][PROD_W-1:0] prod;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            prod <= '0;
        end else begin
            for (int k = 0; k < NW; k++)
                prod[k] <= PROD_W'($signed(win[k/K][k%K])) * PROD_W'($signed(act_w[k]));
        end
    end

    // ---- stage 3: sum, saturate, ReLU ----
    logic signed [ACC_W-1:0] sum, sat, res;

    always_comb begin
        sum = ACC_W'($signed(act_b));
        for (int k = 0; k < NW; k++) sum = sum + ACC_W'($signed(prod[k]));
        sat = (sum > SMAX) ? SMAX : (sum < SMIN) ? SMIN : sum;
        res = (act_relu && sat < 0) ? '0 : sat;
    end

    // A new frame flushes everything in flight from the old one.
    logic [3:1] vld_pipe, done_pipe;

    always_ff @(posedge iCLK) begin
        if (iRST || sof_acc) begin
            vld_pipe  <= '0;
            done_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[2:1], qual};
            done_pipe <= {done_pipe[2:1], done_px};
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST)                       oPsum <= '0;
        else if (vld_pipe[2] && !sof_acc) oPsum <= BW_OUT'(res);
    end

    assign oValid = vld_pipe[3];
    assign oDone  = done_pipe[3];

endmodule

// File: tb/tb_conv2d_stream.sv
module tb_conv2d_stream;

    logic              clk = 1'b0;
    logic              rst, wren, relu, sof, valid;
    logic [4:0]        addr;
    logic signed [7:0] wdat, x;
    logic signed [15:0] psum1, psum2;
    logic              ov1, ov2, dn1, dn2;

    int cyc = 0;
    int total = 0;
    int passes = 0;

    logic signed [15:0] q1_val[$], q2_val[$];
    int                 q1_cyc[$], q2_cyc[$];
    bit                 q1_done[$], q2_done[$];
    int                 e1_cyc[$], e1_pos[$], e2_cyc[$], e2_pos[$];

    conv2d_stream #(.K(3), .IMG_W(6), .IMG_H(6), .STRIDE(1), .BW_OUT(16)) dut1 (
        .iCLK(clk), .iRST(rst), .iWren(wren), .iADDR(addr), .iWeight(wdat),
        .iRelu(relu), .iSof(sof), .iValid(valid), .iX(x),
        .oPsum(psum1), .oValid(ov1), .oDone(dn1)
    );

    conv2d_stream #(.K(3), .IMG_W(6), .IMG_H(6), .STRIDE(2), .BW_OUT(16)) dut2 (
        .iCLK(clk), .iRST(rst), .iWren(wren), .iADDR(addr), .iWeight(wdat),
        .iRelu(relu), .iSof(sof), .iValid(valid), .iX(x),
        .oPsum(psum2), .oValid(ov2), .oDone(dn2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ov1) begin q1_val.push_back(psum1); q1_cyc.push_back(cyc); q1_done.push_back(dn1); end
        if (ov2) begin q2_val.push_back(psum2); q2_cyc.push_back(cyc); q2_done.push_back(dn2); end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic clr();
        q1_val.delete(); q1_cyc.delete(); q1_done.delete();
        q2_val.delete(); q2_cyc.delete(); q2_done.delete();
        e1_cyc.delete(); e1_pos.delete(); e2_cyc.delete(); e2_pos.delete();
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        wren = 1'b1; addr = 5'(a); wdat = 8'(d);
        @(negedge clk);
        wren = 1'b0;
    endtask

    // center_only: weight[4]=wv, others 0; else all weights wv. Address 9 = bias.
    task automatic set_w(input bit center_only, input int wv, input int bv);
        for (int a = 0; a < 9; a++) wr(a, (center_only && a != 4) ? 0 : wv);
        wr(9, bv);
    endtask

    // mode 0: pixel = r*6+c, mode 1: pixel = 127. Records the cycle at which
    // each qualifying pixel is presented for both stride settings.
    task automatic run_frame(input int mode, input bit gaps);
        for (int p = 0; p < 36; p++) begin
            int r = p / 6;
            int c = p % 6;
            if (gaps) begin
                int g = $urandom_range(0, 2);
                repeat (g) begin
                    @(negedge clk);
                    valid = 1'b0; sof = 1'b0; x = 8'sd99;
                end
            end
            @(negedge clk);
            valid = 1'b1; sof = (p == 0); x = (mode == 0) ? 8'(p) : 8'sd127;
            if (r >= 2 && c >= 2) begin
                e1_cyc.push_back(cyc); e1_pos.push_back(p);
                if (r % 2 == 0 && c % 2 == 0) begin
                    e2_cyc.push_back(cyc); e2_pos.push_back(p);
                end
            end
        end
        @(negedge clk);
        valid = 1'b0; sof = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // kind 0: value = pixel at window center; else constant cval.
    task automatic check_q(input string tag, input bit sel2, input int kind, input int cval);
        int n, qs;
        n  = sel2 ? e2_cyc.size() : e1_cyc.size();
        qs = sel2 ? q2_val.size() : q1_val.size();
        chk({tag, "_count"}, qs, n);
        for (int i = 0; i < n && i < qs; i++) begin
            int v, cy, dn, pos, ev, ec;
            v   = sel2 ? int'(q2_val[i]) : int'(q1_val[i]);
            cy  = sel2 ? q2_cyc[i] : q1_cyc[i];
            dn  = sel2 ? int'(q2_done[i]) : int'(q1_done[i]);
            pos = sel2 ? e2_pos[i] : e1_pos[i];
            ec  = sel2 ? e2_cyc[i] : e1_cyc[i];
            ev  = (kind == 0) ? ((pos / 6 - 1) * 6 + (pos % 6 - 1)) : cval;
            chk($sformatf("%s_val%0d", tag, i), v, ev);
            chk($sformatf("%s_lat%0d", tag, i), cy, ec + 3);
            chk($sformatf("%s_done%0d", tag, i), dn, (i == n - 1) ? 1 : 0);
        end
    endtask

    initial begin
        rst = 1'b1; wren = 1'b0; addr = '0; wdat = '0;
        relu = 1'b0; sof = 1'b0; valid = 1'b0; x = '0;
        repeat (2) @(negedge clk);
        chk("rst_psum", int'(psum1), 0);
        chk("rst_valid", int'(ov1), 0);
        chk("rst_done", int'(dn1), 0);
        rst = 1'b0;

        // identity kernel on a ramp
        set_w(1'b1, 1, 0);
        clr();
        run_frame(0, 1'b0);
        check_q("ident", 1'b0, 0, 0);

        // positive saturation
        set_w(1'b0, 127, 0);
        clr();
        run_frame(1, 1'b0);
        check_q("satpos", 1'b0, 1, 32767);

        // negative saturation, then ReLU clamps it
        set_w(1'b0, -128, 0);
        clr();
        run_frame(1, 1'b0);
        check_q("satneg", 1'b0, 1, -32768);
        relu = 1'b1;
        clr();
        run_frame(1, 1'b0);
        check_q("relu", 1'b0, 1, 0);
        relu = 1'b0;

        // bias only, stride 2 instance
        set_w(1'b0, 0, 100);
        clr();
        run_frame(1, 1'b0);
        chk("s2_npos", e2_pos.size(), 4);
        if (e2_pos.size() == 4) begin
            chk("s2_pos0", e2_pos[0], 14);
            chk("s2_pos3", e2_pos[3], 28);
        end
        check_q("stride2", 1'b1, 1, 100);

        // identity kernel with random valid gaps
        set_w(1'b1, 1, 0);
        clr();
        run_frame(0, 1'b1);
        check_q("gaps", 1'b0, 0, 0);

        // reset mid-frame with results in flight
        clr();
        for (int p = 0; p < 17; p++) begin
            @(negedge clk);
            valid = 1'b1; sof = (p == 0); x = 8'(p);
        end
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; sof = 1'b0;
        @(negedge clk);
        chk("midrst_psum", int'(psum1), 0);
        chk("midrst_valid", int'(ov1), 0);
        chk("midrst_done", int'(dn1), 0);
        chk("midrst_nout", q1_val.size(), 1);
        if (q1_val.size() > 0) chk("midrst_first", int'(q1_val[0]), 7);
        rst = 1'b0;
        for (int p = 17; p < 36; p++) begin
            @(negedge clk);
            valid = 1'b1; sof = 1'b0; x = 8'(p);
        end
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("nosof_nout", q1_val.size(), 1);
        chk("nosof_psum", int'(psum1), 0);

        set_w(1'b1, 1, 0);
        clr();
        run_frame(0, 1'b0);
        check_q("postrst", 1'b0, 0, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/conv2d_stream.md
CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 SHALL have parameter K, default 5: square kernel size; legal values are 3 or 5.
REQ-002 SHALL have parameter IMG_W, default 32: image width in pixels.
REQ-003 SHALL have parameter IMG_H, default 32: image height in pixels.
REQ-004 SHALL have parameter STRIDE, default 1: output stride in both axes; legal values are 1 or 2.
REQ-005 SHALL have parameter BW_OUT, default 16: output width in bits.
REQ-006 SHALL have port iCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port iRST, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port iWren, input, 1 bit: weight/bias write strobe.
REQ-009 SHALL have port iADDR, input, 5 bits: addresses 0..K*K-1 select weights in raster order; address K*K selects the bias; other addresses are ignored.
REQ-010 SHALL have port iWeight, input, 8 bits signed: write data.
REQ-011 SHALL have port iRelu, input, 1 bit: ReLU enable; sampled only at iSof.
REQ-012 SHALL have port iSof, input, 1 bit: start of frame; qualifies the first pixel of a frame (valid only with iValid).
REQ-013 SHALL have port iValid, input, 1 bit: pixel valid.
REQ-014 SHALL have port iX, input, 8 bits signed: pixel data, raster order.
REQ-015 SHALL have port oPsum, output, BW_OUT bits signed: convolution result.
REQ-016 SHALL have port oValid, output, 1 bit: oPsum is valid this cycle.
REQ-017 SHALL have port oDone, output, 1 bit: one-cycle pulse coincident with the last output of a frame.

Function
REQ-018 SHALL write iWeight into the shadow register at iADDR on every iWren cycle, at any time.
REQ-019 SHALL copy shadow weights, bias and iRelu into the active set on an accepted iSof pixel, so a frame uses a constant weight set.
REQ-020 SHALL accept a pixel only when iValid=1; with iValid=0, column/row counters, line buffers and window SHALL hold.
REQ-021 SHALL reset col/row counters to 0 on accepted iSof; col wraps at IMG_W-1 with row+1; accepted pixels after (IMG_H-1, IMG_W-1) without iSof SHALL be ignored.
REQ-022 SHALL keep K-1 line buffers of IMG_W pixels and a KxK window register, shifted once per accepted pixel.
REQ-023 SHALL treat the window as complete when row>=K-1 and col>=K-1 (bottom-right = current pixel); no padding.
REQ-024 SHALL emit output only for complete windows with (row-K+1)%STRIDE==0 and (col-K+1)%STRIDE==0.
REQ-025 SHALL form the result as sum of w[i]*x[i] (16-bit signed products) plus sign-extended bias, in a 21-bit accumulator without overflow.
REQ-026 SHALL saturate the sum to the signed BW_OUT range, then force negative results to 0 when the active ReLU bit is 1.
REQ-027 SHALL run a 3-stage pipeline: window capture, registered products, registered sum/saturate/ReLU; oValid SHALL be asserted exactly 3 cycles after the qualifying pixel is accepted.
REQ-028 SHALL advance the output pipeline every cycle independent of iValid; oPsum SHALL hold its last value when oValid=0.
REQ-029 SHALL assert oDone with oValid for the output whose window ends at the last qualifying position of the frame.
REQ-030 SHALL discard pending pipeline outputs of the old frame when iSof arrives mid-frame.

Reset
REQ-031 SHALL clear on iRST all weights (shadow and active), bias, ReLU bit, counters, window, pipeline valid bits, oPsum=0, oValid=0 and oDone=0.
REQ-032 SHALL NOT clear line-buffer storage on iRST; it is masked by the window-complete rule.
REQ-033 SHALL require a new iSof after reset before any pixel is accepted.

Structure
REQ-034 SHALL place the accumulator width (21), the pixel/weight width (8) and the bias address function (K*K) in shared package conv_pkg.
REQ-035 SHALL implement line storage as one sub-module, conv_line_buf (parametrised depth IMG_W, width 8, enable), instantiated K-1 times.

Verification (bench K=3, IMG_W=IMG_H=6, BW_OUT=16)
REQ-036 SHALL test: weight[4]=1, others 0, bias 0, pixel = r*6+c, STRIDE=1 -> 16 outputs, output (r,c) = (r-1)*6+(c-1), oDone on the 16th output.
REQ-037 SHALL test: all weights 127, all pixels 127 -> every output = 32767 (saturated).
REQ-038 SHALL test: all weights -128, pixels 127 -> -32768; with iRelu=1 at iSof -> 0.
REQ-039 SHALL test: zero weights, bias 100, STRIDE=2 -> exactly 4 outputs of 100, at windows ending (2,2), (2,4), (4,2), (4,4).
REQ-040 SHALL test: the same stimulus as REQ-036 with random iValid gaps -> identical values in identical order, each output 3 cycles after its pixel.
REQ-041 SHALL test: iRST asserted mid-frame -> outputs 0 next cycle, no oValid until a new iSof frame completes a window.
